// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with column synchroniser,
// press/release debounce and 4-bit key encoding. Auto-repeat: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000,
  parameter int PRESS_HOLD   = 8,
  parameter int REPEAT_CYC   = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_val,
  output logic       key_press,
  output logic       key_busy
);

  typedef enum logic [2:0] {
    SCAN         = 3'd0,
    DEBOUNCE     = 3'd1,
    LOAD         = 3'd2,
    PRESS        = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int HOLD_W = $clog2(PRESS_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PRESS_HOLD - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || PRESS_HOLD < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  // {valid, index}: valid only when exactly one column is pulled low
  function automatic logic [2:0] decode_col(input logic [3:0] cols);
    case (cols)
      4'b1110: decode_col = {1'b1, 2'd0};
      4'b1101: decode_col = {1'b1, 2'd1};
      4'b1011: decode_col = {1'b1, 2'd2};
      4'b0111: decode_col = {1'b1, 2'd3};
      default: decode_col = {1'b0, 2'd0};
    endcase
  endfunction

  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0:    encode_key = 4'd1;
      4'h1:    encode_key = 4'd2;
      4'h2:    encode_key = 4'd3;
      4'h3:    encode_key = 4'd10;
      4'h4:    encode_key = 4'd4;
      4'h5:    encode_key = 4'd5;
      4'h6:    encode_key = 4'd6;
      4'h7:    encode_key = 4'd11;
      4'h8:    encode_key = 4'd7;
      4'h9:    encode_key = 4'd8;
      4'hA:    encode_key = 4'd9;
      4'hB:    encode_key = 4'd12;
      4'hC:    encode_key = 4'd14;
      4'hD:    encode_key = 4'd0;
      4'hE:    encode_key = 4'd15;
      4'hF:    encode_key = 4'd13;
      default: encode_key = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    case (row)
      2'd0:    row_drive = 4'b1110;
      2'd1:    row_drive = 4'b1101;
      2'd2:    row_drive = 4'b1011;
      2'd3:    row_drive = 4'b0111;
      default: row_drive = 4'b1111;
    endcase
  endfunction

  logic [3:0]        sync_meta_r, col_sync_r, col_s;
  state_t            state_r, state_next_s;
  logic [1:0]        row_r, row_next_s;
  logic [DIV_W-1:0]  div_r, div_next_s;
  logic [DEB_W-1:0]  deb_r, deb_next_s;
  logic [HOLD_W-1:0] hold_r, hold_next_s;
  logic [3:0]        col_lat_r, col_lat_next_s;
  logic [1:0]        col_idx_r, col_idx_next_s;
  logic [3:0]        key_val_r, key_val_next_s;
  logic [2:0]        col_dec_s;
  logic [3:0]        row_out_r;
  logic              key_press_r, key_busy_r;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYC + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);
  logic [RPT_W-1:0]  rpt_r, rpt_next_s;
`endif

  assign col_s = col_sync_r;

  // Two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 4'hF;
      col_sync_r  <= 4'hF;
    end else begin
      sync_meta_r <= col_in;
      col_sync_r  <= sync_meta_r;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next_s   = state_r;
    row_next_s     = row_r;
    div_next_s     = div_r;
    deb_next_s     = deb_r;
    hold_next_s    = hold_r;
    col_lat_next_s = col_lat_r;
    col_idx_next_s = col_idx_r;
    key_val_next_s = key_val_r;
    col_dec_s      = decode_col(col_s);
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_next_s     = {RPT_W{1'b0}};
`endif
    case (state_r)
      SCAN: begin
        if (div_r == DIV_LAST) begin
          div_next_s = {DIV_W{1'b0}};
          if (col_dec_s[2]) begin
            state_next_s   = DEBOUNCE;
            col_lat_next_s = col_s;
            col_idx_next_s = col_dec_s[1:0];
            deb_next_s     = {DEB_W{1'b0}};
          end else begin
            row_next_s = row_r + 2'd1;
          end
        end else begin
          div_next_s = div_r + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s == col_lat_r) begin
          if (deb_r == DEB_LAST) begin
            state_next_s   = LOAD;
            deb_next_s     = {DEB_W{1'b0}};
            key_val_next_s = encode_key(row_r, col_idx_r);
          end else begin
            deb_next_s = deb_r + 1'b1;
          end
        end else begin
          state_next_s = SCAN;
          row_next_s   = row_r + 2'd1;
          deb_next_s   = {DEB_W{1'b0}};
        end
      end
      LOAD: begin
        state_next_s = PRESS;
        hold_next_s  = {HOLD_W{1'b0}};
      end
      PRESS: begin
        if (hold_r == HOLD_LAST) begin
          state_next_s = WAIT_RELEASE;
          hold_next_s  = {HOLD_W{1'b0}};
          deb_next_s   = {DEB_W{1'b0}};
        end else begin
          hold_next_s = hold_r + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (col_s == 4'hF) begin
          if (deb_r == DEB_LAST) begin
            state_next_s = SCAN;
            row_next_s   = row_r + 2'd1;
            deb_next_s   = {DEB_W{1'b0}};
            div_next_s   = {DIV_W{1'b0}};
          end else begin
            deb_next_s = deb_r + 1'b1;
          end
        end else begin
          deb_next_s = {DEB_W{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
          // Hold timer only runs while the latched column itself stays low
          if (col_s[col_idx_r] == 1'b0) begin
            if (rpt_r == RPT_LAST) begin
              state_next_s = PRESS;
              hold_next_s  = {HOLD_W{1'b0}};
            end else begin
              rpt_next_s = rpt_r + 1'b1;
            end
          end else begin
            rpt_next_s = {RPT_W{1'b0}};
          end
`endif
        end
      end
      default: begin
        state_next_s = SCAN;
        row_next_s   = 2'd0;
        div_next_s   = {DIV_W{1'b0}};
        deb_next_s   = {DEB_W{1'b0}};
        hold_next_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SCAN;
      row_r       <= 2'd0;
      div_r       <= {DIV_W{1'b0}};
      deb_r       <= {DEB_W{1'b0}};
      hold_r      <= {HOLD_W{1'b0}};
      col_lat_r   <= 4'hF;
      col_idx_r   <= 2'd0;
      key_val_r   <= 4'd0;
      row_out_r   <= 4'b1110;
      key_press_r <= 1'b0;
      key_busy_r  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_r       <= {RPT_W{1'b0}};
`endif
    end else begin
      state_r     <= state_next_s;
      row_r       <= row_next_s;
      div_r       <= div_next_s;
      deb_r       <= deb_next_s;
      hold_r      <= hold_next_s;
      col_lat_r   <= col_lat_next_s;
      col_idx_r   <= col_idx_next_s;
      key_val_r   <= key_val_next_s;
      row_out_r   <= row_drive(row_next_s);
      key_press_r <= (state_next_s == PRESS);
      key_busy_r  <= (state_next_s != SCAN);
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_r       <= rpt_next_s;
`endif
    end
  end

  assign row_out   = row_out_r;
  assign key_val   = key_val_r;
  assign key_press = key_press_r;
  assign key_busy  = key_busy_r;

endmodule
